// File: rtl/stepper_axil_slave.sv
// AXI4-Lite register slave driving a step/dir pulse engine for an external stepper driver.
// Optional macro STEPPER_IRQ_EN adds an irq output and a write-1-to-clear done bit in STATUS.
module stepper_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
`ifdef STEPPER_IRQ_EN
  output logic                            irq,
`endif
  output logic                            step_out,
  output logic                            dir_out
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          awready_q, awready_d, bvalid_q, bvalid_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] ctrl_q, ctrl_d, period_q, period_d, steps_q, steps_d, scratch_q, scratch_d;
  logic [DW-1:0] rem_q, rem_d, cnt_q, cnt_d, lo_q, lo_d;
  logic          dir_q, dir_d;
  logic          wr_fire, rd_fire, done_clr;
  logic [2:0]    wr_idx, rd_idx;
  logic [DW-1:0] status, per_eff;
  logic          unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old,
                                                input logic [DW-1:0] din,
                                                input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DW/8; i++)
      if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready_q & S_AXI_ARVALID;
  assign wr_idx  = S_AXI_AWADDR[4:2];
  assign rd_idx  = S_AXI_ARADDR[4:2];
  assign status  = {rem_q[23:0], 6'b0, (state_q == S_DONE), (state_q == S_HIGH) || (state_q == S_LOW)};
  // Periods below 2 would give a zero-length high or low phase, so they are clamped.
  assign per_eff = (period_q < 32'd2) ? 32'd2 : period_q;

`ifdef STEPPER_IRQ_EN
  assign done_clr = wr_fire && (wr_idx == 3'd4) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
`else
  assign done_clr = 1'b0;
`endif

  always_comb begin
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    steps_d   = steps_q;
    scratch_d = scratch_q;

    if (wr_fire) begin
      bvalid_d = 1'b1;
      case (wr_idx)
        3'd0:    ctrl_d    = merge_bytes(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
        3'd1:    period_d  = merge_bytes(period_q, S_AXI_WDATA, S_AXI_WSTRB);
        3'd2:    steps_d   = merge_bytes(steps_q, S_AXI_WDATA, S_AXI_WSTRB);
        3'd3:    scratch_d = merge_bytes(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
        default: ;
      endcase
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Reads sample the pre-edge register values, so a same-cycle write is not visible.
    if (rd_fire) begin
      rvalid_d = 1'b1;
      case (rd_idx)
        3'd0:    rdata_d = ctrl_q;
        3'd1:    rdata_d = period_q;
        3'd2:    rdata_d = steps_q;
        3'd3:    rdata_d = scratch_q;
        3'd4:    rdata_d = status;
        default: rdata_d = '0;
      endcase
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0] && (steps_q != '0)) begin
          dir_d   = ctrl_q[1];
          rem_d   = steps_q;
          cnt_d   = (per_eff >> 1) - 32'd1;
          lo_d    = per_eff - (per_eff >> 1);
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          cnt_d   = lo_q - 32'd1;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_LOW: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = (per_eff >> 1) - 32'd1;
            lo_d    = per_eff - (per_eff >> 1);
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        if (!ctrl_q[0] || done_clr) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      period_q  <= '0;
      steps_q   <= '0;
      scratch_q <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      period_q  <= period_d;
      steps_q   <= steps_d;
      scratch_q <= scratch_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign step_out      = (state_q == S_HIGH);
  assign dir_out       = dir_q;
`ifdef STEPPER_IRQ_EN
  assign irq           = (state_q == S_DONE);
`endif

endmodule
